pc_stack_unit: RTL and testbench
================================

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 SHALL have parameter AW, default 19, program-counter and return-address width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, return-stack entry count, power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit, advance enable; low = stall.
REQ-006 SHALL have ports branch, jump, call, ret, each input, 1 bit, control-flow strobes from the decoder.
REQ-007 SHALL have port br_taken, input, 1 bit, branch condition result (already resolved for BEQ/BNE).
REQ-008 SHALL have port target, input, AW bits, jump/branch/call destination address.
REQ-009 SHALL have port pc, output, AW bits, current fetch address (registered).
REQ-010 SHALL have port redirect, output, 1 bit, registered one-cycle pulse after a non-sequential PC load.
REQ-011 SHALL have port sp, output, log2(DEPTH)+1 bits, current number of stacked return addresses.
REQ-012 SHALL have port ovf, output, 1 bit, sticky overflow flag.
REQ-013 SHALL have port unf, output, 1 bit, sticky underflow flag.

Function
REQ-014 SHALL, on a rising edge with en=1, load pc with exactly one next-PC source, chosen by fixed priority ret > call > jump > (branch & br_taken) > sequential.
REQ-015 SHALL compute sequential next-PC as pc+1 modulo 2^AW, so that all-ones wraps to 0 and no flag is raised.
REQ-016 SHALL, on ret with sp>0, load pc from the top-of-stack entry and decrement sp by 1.
REQ-017 SHALL, on call with sp<DEPTH, push pc+1 (mod 2^AW), increment sp by 1, and load pc with target.
REQ-018 SHALL, on call with sp=DEPTH, load pc with target, leave the stack contents and sp unchanged, and set ovf.
REQ-019 SHALL, on ret with sp=0, take the sequential pc+1 path, leave sp at 0, set unf, and hold redirect low.
REQ-020 SHALL, on jump, or on branch with br_taken=1, load pc with target; branch with br_taken=0 SHALL take the sequential path.
REQ-021 SHALL, when strobes are asserted simultaneously, act only on the highest-priority strobe; lower strobes SHALL have no side effect (no push, no pop, no flag).
REQ-022 SHALL drive redirect to 1 for exactly the cycle following any edge where pc was loaded from target or from the stack, and to 0 otherwise.
REQ-023 SHALL, on an edge with en=0, hold pc, sp, stack contents, ovf and unf, force redirect to 0, and ignore all strobes.
REQ-024 SHALL clear ovf and unf only by reset.
REQ-025 SHALL have one-cycle latency: a strobe sampled at edge N is reflected on pc after edge N.
REQ-026 SHALL treat the stack as a LIFO indexed by sp, where a push writes entry[sp] and a pop reads entry[sp-1], with no read-during-write hazard because push and pop never occur on the same edge.

Reset
REQ-027 SHALL, while rst=1 (asynchronously, regardless of clk), force pc=0, sp=0, redirect=0, ovf=0 and unf=0.
REQ-028 SHALL NOT require stack-entry storage to be reset, but entries SHALL be unreachable after reset because sp=0.
REQ-029 SHALL, when rst is asserted mid-operation, discard any in-flight call/ret, so that the first edge after deassertion with en=1 and no strobes yields pc=1.

Verification
REQ-030 SHALL be verified by: reset, then 4 edges with en=1 and no strobes -> pc=4, redirect=0 throughout.
REQ-031 SHALL be verified by: at pc=0x00010, call with target=0x00100 -> pc=0x00100, sp=1, redirect=1; then ret -> pc=0x00011, sp=0, redirect=1.
REQ-032 SHALL be verified by: 9 consecutive calls with DEPTH=8 -> sp=8 and ovf=1 after the 9th; then 8 rets -> return addresses popped in reverse order, sp=0.
REQ-033 SHALL be verified by: ret with sp=0 at pc=0x00020 -> pc=0x00021, unf=1, redirect=0; unf stays 1 until rst.
REQ-034 SHALL be verified by: call, jump and branch (br_taken=1) asserted together with target=0x00200 -> pc=0x00200, sp=+1 (call wins); then en=0 with ret asserted -> no change.
REQ-035 SHALL be verified by: with pc=0x7FFFF, an edge with no strobes -> pc=0x00000 and no flags; and rst asserted between clock edges -> pc=0 immediately, before the next edge.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Purpose : program-counter sequencer with a return-address stack (call/ret), jump and branch redirection.
// Latency : one cycle; strobes sampled on a rising edge are reflected on pc, sp, redirect and flags after that edge.
// Backpress: en=0 stalls the unit, holding all state and ignoring strobes; no valid/ready handshake.
//
// Ports:
//   clk, rst                 - single clock; asynchronous active-high reset
//   en                       - advance enable (low = stall)
//   branch/jump/call/ret     - control-flow strobes, priority ret > call > jump > taken branch
//   br_taken                 - resolved branch condition
//   target                   - destination for jump/branch/call
//   pc                       - registered fetch address
//   redirect                 - one-cycle pulse after pc was loaded from target or stack
//   sp                       - number of stacked return addresses (0..DEPTH)
//   ovf, unf                 - sticky overflow/underflow, cleared only by reset
module pc_stack_unit #(
  parameter int AW    = 19,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   branch,
  input  logic                   jump,
  input  logic                   call,
  input  logic                   ret,
  input  logic                   br_taken,
  input  logic [AW-1:0]          target,
  output logic [AW-1:0]          pc,
  output logic                   redirect,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   ovf,
  output logic                   unf
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  // Return-address storage; not reset, unreachable while sp=0.
  logic [AW-1:0] stack [DEPTH];

  logic [AW-1:0] pc_seq;
  logic [AW-1:0] tos;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          empty;
  logic          full;

  logic [AW-1:0] next_pc;
  logic          next_redirect;
  logic          do_push;
  logic          do_pop;
  logic          set_ovf;
  logic          set_unf;

  assign pc_seq = pc + AW'(1);          // wraps naturally modulo 2^AW
  assign empty  = (sp == '0);
  assign full   = (sp == SP_FULL);
  // sp < DEPTH whenever a push happens, so the low bits index entry[sp].
  assign wr_idx = sp[IW-1:0];
  assign rd_idx = sp[IW-1:0] - IW'(1);
  assign tos    = stack[rd_idx];

  // Only the highest-priority strobe takes effect; lower ones are masked.
  always_comb begin
    next_pc       = pc_seq;
    next_redirect = 1'b0;
    do_push       = 1'b0;
    do_pop        = 1'b0;
    set_ovf       = 1'b0;
    set_unf       = 1'b0;
    if (ret) begin
      if (!empty) begin
        next_pc       = tos;
        next_redirect = 1'b1;
        do_pop        = 1'b1;
      end else begin
        // Underflow falls through to the sequential path without a redirect.
        set_unf = 1'b1;
      end
    end else if (call) begin
      next_pc       = target;
      next_redirect = 1'b1;
      if (!full) begin
        do_push = 1'b1;
      end else begin
        set_ovf = 1'b1;
      end
    end else if (jump) begin
      next_pc       = target;
      next_redirect = 1'b1;
    end else if (branch && br_taken) begin
      next_pc       = target;
      next_redirect = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      sp       <= '0;
      redirect <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else if (en) begin
      pc       <= next_pc;
      redirect <= next_redirect;
      if (do_push) begin
        sp <= sp + SPW'(1);
      end else if (do_pop) begin
        sp <= sp - SPW'(1);
      end
      if (set_ovf) begin
        ovf <= 1'b1;
      end
      if (set_unf) begin
        unf <= 1'b1;
      end
    end else begin
      redirect <= 1'b0;
    end
  end

  // A push during reset is blocked so an in-flight call leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && en && do_push) begin
      stack[wr_idx] <= pc_seq;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Purpose : directed test of pc_stack_unit with a scoreboard of expected output states.
// Latency : each step drives strobes, waits one rising edge, then compares 1 time unit later.
// Backpress: stall behaviour exercised through en=0 steps.
module tb_pc_stack_unit;

  localparam int AW    = 19;
  localparam int DEPTH = 8;
  localparam int SPW   = $clog2(DEPTH) + 1;

  logic           clk;
  logic           rst;
  logic           en;
  logic           branch;
  logic           jump;
  logic           call;
  logic           ret;
  logic           br_taken;
  logic [AW-1:0]  target;
  logic [AW-1:0]  pc;
  logic           redirect;
  logic [SPW-1:0] sp;
  logic           ovf;
  logic           unf;

  typedef struct {
    logic [AW-1:0]  pc;
    logic [SPW-1:0] sp;
    logic           redirect;
    logic           ovf;
    logic           unf;
    string          tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  pc_stack_unit #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .branch   (branch),
    .jump     (jump),
    .call     (call),
    .ret      (ret),
    .br_taken (br_taken),
    .target   (target),
    .pc       (pc),
    .redirect (redirect),
    .sp       (sp),
    .ovf      (ovf),
    .unf      (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_state(input logic [AW-1:0] e_pc, input int e_sp, input logic e_rd,
                              input logic e_ovf, input logic e_unf, input string tag);
    exp_t e;
    e.pc = e_pc;
    e.sp = SPW'(e_sp);
    e.redirect = e_rd;
    e.ovf = e_ovf;
    e.unf = e_unf;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty got size 0 want >0");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (pc === e.pc) else begin
        errors++;
        $error("FAIL %s.pc got %h want %h", e.tag, pc, e.pc);
      end
      checks++;
      assert (sp === e.sp) else begin
        errors++;
        $error("FAIL %s.sp got %0d want %0d", e.tag, sp, e.sp);
      end
      checks++;
      assert (redirect === e.redirect) else begin
        errors++;
        $error("FAIL %s.redirect got %b want %b", e.tag, redirect, e.redirect);
      end
      checks++;
      assert (ovf === e.ovf) else begin
        errors++;
        $error("FAIL %s.ovf got %b want %b", e.tag, ovf, e.ovf);
      end
      checks++;
      assert (unf === e.unf) else begin
        errors++;
        $error("FAIL %s.unf got %b want %b", e.tag, unf, e.unf);
      end
    end
  endtask

  task automatic drive(input logic i_en, input logic i_br, input logic i_tk, input logic i_jp,
                       input logic i_cl, input logic i_rt, input logic [AW-1:0] i_tgt);
    en = i_en; branch = i_br; br_taken = i_tk; jump = i_jp; call = i_cl; ret = i_rt; target = i_tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    logic [AW-1:0] ra [DEPTH];

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, '0);
    #3;
    expect_state(19'h0, 0, 0, 0, 0, "reset");
    check_now();
    @(negedge clk);
    rst = 1'b0;

    // Sequential counting.
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 0, 0, 0, '0);
      expect_state(AW'(i), 0, 0, 0, 0, $sformatf("seq%0d", i));
      tick();
    end

    // Call / return round trip from 0x10.
    drive(1, 0, 0, 1, 0, 0, 19'h00010);
    expect_state(19'h00010, 0, 1, 0, 0, "jump10"); tick();
    drive(1, 0, 0, 0, 1, 0, 19'h00100);
    expect_state(19'h00100, 1, 1, 0, 0, "call100"); tick();
    drive(1, 0, 0, 0, 0, 1, '0);
    expect_state(19'h00011, 0, 1, 0, 0, "ret11"); tick();

    // Fill the stack, then overflow on the 9th call.
    for (int k = 0; k <= DEPTH; k++) begin
      logic [AW-1:0] t;
      t = 19'h01000 + AW'(k * 16);
      if (k < DEPTH) ra[k] = (k == 0) ? 19'h00012 : 19'h01000 + AW'((k - 1) * 16) + 19'h1;
      drive(1, 0, 0, 0, 1, 0, t);
      expect_state(t, (k < DEPTH) ? k + 1 : DEPTH, 1, (k == DEPTH), 0, $sformatf("fill%0d", k));
      tick();
    end
    // Drain in reverse order; overflow stays sticky.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      drive(1, 0, 0, 0, 0, 1, '0);
      expect_state(ra[k], k, 1, 1, 0, $sformatf("drain%0d", k));
      tick();
    end

    // Underflow at 0x20.
    drive(1, 0, 0, 1, 0, 0, 19'h00020);
    expect_state(19'h00020, 0, 1, 1, 0, "jump20"); tick();
    drive(1, 0, 0, 0, 0, 1, '0);
    expect_state(19'h00021, 0, 0, 1, 1, "underflow"); tick();
    drive(1, 0, 0, 0, 0, 0, '0);
    expect_state(19'h00022, 0, 0, 1, 1, "unf_sticky"); tick();

    // call + jump + taken branch together: call wins.
    drive(1, 1, 1, 1, 1, 0, 19'h00200);
    expect_state(19'h00200, 1, 1, 1, 1, "prio_call"); tick();
    // Stall with ret asserted: nothing moves, redirect drops.
    drive(0, 0, 0, 0, 0, 1, '0);
    expect_state(19'h00200, 1, 0, 1, 1, "stall_ret"); tick();
    drive(1, 0, 0, 0, 0, 1, '0);
    expect_state(19'h00023, 0, 1, 1, 1, "ret_after_stall"); tick();

    // Branch not taken is sequential even with a target; taken branch redirects.
    drive(1, 1, 0, 0, 0, 0, 19'h00300);
    expect_state(19'h00024, 0, 0, 1, 1, "br_not_taken"); tick();
    drive(1, 1, 1, 0, 0, 0, 19'h00300);
    expect_state(19'h00300, 0, 1, 1, 1, "br_taken"); tick();
    // ret beats call: pop without push.
    drive(1, 0, 0, 0, 1, 0, 19'h00400);
    expect_state(19'h00400, 1, 1, 1, 1, "call400"); tick();
    drive(1, 0, 0, 0, 1, 1, 19'h00500);
    expect_state(19'h00301, 0, 1, 1, 1, "prio_ret"); tick();

    // Asynchronous reset mid-operation with a call pending on the stack and ret asserted.
    drive(1, 0, 0, 0, 1, 0, 19'h00600);
    expect_state(19'h00600, 1, 1, 1, 1, "call600"); tick();
    drive(1, 0, 0, 0, 0, 1, '0);
    #2;
    rst = 1'b1;
    #1;
    expect_state(19'h0, 0, 0, 0, 0, "async_rst"); check_now();
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, '0);
    expect_state(19'h00001, 0, 0, 0, 0, "post_rst"); tick();

    // Wrap from all-ones with no flags.
    drive(1, 0, 0, 1, 0, 0, 19'h7FFFF);
    expect_state(19'h7FFFF, 0, 1, 0, 0, "jump_max"); tick();
    drive(1, 0, 0, 0, 0, 0, '0);
    expect_state(19'h00000, 0, 0, 0, 0, "wrap"); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
